// File: rtl/pattern.sv
// Serial "00"/"11" run detector: Moore FSM, one bit sampled per rising clock edge.
// detect is registered together with the state, so it is glitch-free.
module pattern #(
    parameter bit OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic inbits,
    output logic detect
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_L0   = 3'd1,
        S_L1   = 3'd2,
        S_D0   = 3'd3,
        S_D1   = 3'd4
    } state_t;

    state_t state;

    // detect is loaded with the decode of the state being entered, so it always equals (state is S_D0 or S_D1).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            detect <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    state  <= inbits ? S_L1 : S_L0;
                    detect <= 1'b0;
                end
                S_L0: begin
                    state  <= inbits ? S_L1 : S_D0;
                    detect <= !inbits;
                end
                S_L1: begin
                    state  <= inbits ? S_D1 : S_L0;
                    detect <= inbits;
                end
                S_D0: begin
                    if (inbits) begin
                        state  <= S_L1;
                        detect <= 1'b0;
                    end else begin
                        state  <= OVERLAP ? S_D0 : S_L0;
                        detect <= OVERLAP;
                    end
                end
                S_D1: begin
                    if (!inbits) begin
                        state  <= S_L0;
                        detect <= 1'b0;
                    end else begin
                        state  <= OVERLAP ? S_D1 : S_L1;
                        detect <= OVERLAP;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    detect <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern.sv
// Directed bench for pattern: overlapping and non-overlapping instances share one
// input stream; expected detect values are queued when a bit is driven.
module tb_pattern;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic inbits = 1'b0;
    logic detect_ov;
    logic detect_no;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic e_ov;
        logic e_no;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    pattern #(.OVERLAP(1'b1)) dut_ov (
        .clk    (clk),
        .reset  (reset),
        .inbits (inbits),
        .detect (detect_ov)
    );

    pattern #(.OVERLAP(1'b0)) dut_no (
        .clk    (clk),
        .reset  (reset),
        .inbits (inbits),
        .detect (detect_no)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives one bit, checks after the sampling edge, returns at the next negedge.
    task automatic step(input string tag, input logic b, input logic e_ov, input logic e_no);
        exp_t e;
        inbits = b;
        e.e_ov = e_ov;
        e.e_no = e_no;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, "/ov"}, detect_ov, e.e_ov);
        check({tag, "/no"}, detect_no, e.e_no);
        @(negedge clk);
    endtask

    // Bits and expectations are written MSB-first: bit i of the stream is bits[n-1-i].
    task automatic run(input string tag, input logic [31:0] bits, input logic [31:0] x_ov,
                       input logic [31:0] x_no, input int n);
        for (int i = 0; i < n; i++)
            step($sformatf("%s[%0d]", tag, i), bits[n-1-i], x_ov[n-1-i], x_no[n-1-i]);
    endtask

    // Called at a negedge; holds reset with random data and returns at a negedge with reset released.
    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        check({tag, "/async_ov"}, detect_ov, 1'b0);
        check({tag, "/async_no"}, detect_no, 1'b0);
        for (int i = 0; i < 3; i++) begin
            inbits = 1'($urandom);
            @(posedge clk);
            #1;
            check($sformatf("%s/hold%0d_ov", tag, i), detect_ov, 1'b0);
            check($sformatf("%s/hold%0d_no", tag, i), detect_no, 1'b0);
            @(negedge clk);
        end
        reset = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        do_reset("rst0");

        run("s1011001", 32'b1011001, 32'b0001010, 32'b0001010, 7);
        do_reset("rst1");

        run("s0000", 32'b0000, 32'b0111, 32'b0101, 4);
        // Asynchronous reset while both instances sit in S_D0: detect must drop without a clock edge.
        #2;
        reset = 1'b0;
        #1;
        check("async_mid_ov", detect_ov, 1'b0);
        check("async_mid_no", detect_no, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        run("s11111", 32'b11111, 32'b01111, 32'b01010, 5);
        do_reset("rst2");

        run("alt20", 32'b01010101010101010101, 32'b0, 32'b0, 20);
        do_reset("rst3");

        // A "11" pair split by a reset pulse is not a match.
        step("brk_a", 1'b1, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        step("brk_b", 1'b1, 1'b0, 1'b0);
        step("brk_c", 1'b1, 1'b1, 1'b1);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_drain: observed=%0d expected=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
